iq_free_list: RTL and testbench

- Issue-queue slot manager at the far end of the round-robin select path.
- The select stage emits one-hot grant vectors per issue lane. This block decodes each grant to a binary slot index, registers it for the payload-RAM read, and returns the granted slots to the free pool.
- It also supplies dispatch with up to DISPATCH_WIDTH free slot indices per cycle.
- It clears squashed slots on flush.

---
 rtl/iq_free_pkg.sv | 32 +++
 rtl/iq_lowest_k_select.sv | 24 ++
 rtl/iq_free_list.sv | 101 ++++++++++
 tb/tb_iq_free_list.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/iq_free_pkg.sv
// Shared sizing, types and bit-vector helpers for the issue-queue free list.
package iq_free_pkg;

    localparam int IQ_SIZE        = 32;
    localparam int SIZE_LOG       = 5;
    localparam int DISPATCH_WIDTH = 4;
    localparam int ISSUE_WIDTH    = 4;

    typedef logic [SIZE_LOG-1:0] iqIdx_t;
    typedef logic [IQ_SIZE-1:0]  iqVec_t;
    typedef logic [SIZE_LOG:0]   iqCnt_t;

    // One-hot to binary; a vector with several bits set yields its lowest set bit.
    function automatic iqIdx_t onehot_to_idx(input iqVec_t vec);
        iqIdx_t idx;
        idx = '0;
        for (int i = IQ_SIZE - 1; i >= 0; i--) begin
            if (vec[i]) idx = iqIdx_t'(i);
        end
        return idx;
    endfunction

    function automatic iqCnt_t popcount(input iqVec_t vec);
        iqCnt_t cnt;
        cnt = '0;
        for (int i = 0; i < IQ_SIZE; i++) begin
            cnt = cnt + iqCnt_t'(vec[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/iq_lowest_k_select.sv
// Picks the lowest DISPATCH_WIDTH set bits of the free vector, ascending by lane.
module iq_lowest_k_select
    import iq_free_pkg::*;
(
    input  iqVec_t                                     free_vec,
    output logic [DISPATCH_WIDTH-1:0][SIZE_LOG-1:0]    pick_idx,
    output logic [DISPATCH_WIDTH-1:0]                  pick_valid
);

    iqVec_t remaining;

    // Each stage takes the lowest remaining bit, then masks it off for the next stage.
    always_comb begin
        remaining  = free_vec;
        pick_idx   = '0;
        pick_valid = '0;
        for (int k = 0; k < DISPATCH_WIDTH; k++) begin
            pick_valid[k]          = |remaining;
            pick_idx[k]            = onehot_to_idx(remaining);
            remaining[pick_idx[k]] = 1'b0;
        end
    end

endmodule

// File: rtl/iq_free_list.sv
// Issue-queue slot manager: allocates free slots to dispatch, decodes select
// grants into registered indices, and returns granted or flushed slots to the pool.
module iq_free_list
    import iq_free_pkg::*;
(
    input  logic                              clk,
    input  logic                              reset,
    input  logic [ISSUE_WIDTH*IQ_SIZE-1:0]    grantVec_i,
    output logic [ISSUE_WIDTH*SIZE_LOG-1:0]   grantIdx_o,
    output logic [ISSUE_WIDTH-1:0]            grantValid_o,
    input  logic [DISPATCH_WIDTH-1:0]         dispatchValid_i,
    output logic [DISPATCH_WIDTH*SIZE_LOG-1:0] freeEntry_o,
    output logic                              entriesAvail_o,
    input  logic [IQ_SIZE-1:0]                flushVec_i,
    output logic [SIZE_LOG:0]                 freeCnt_o,
    output logic                              protoErr_o
);

    iqVec_t free_vec_q, free_vec_d;
    iqCnt_t free_cnt_q, free_cnt_d;
    logic [ISSUE_WIDTH-1:0][SIZE_LOG-1:0] grant_idx_q, grant_idx_d;
    logic [ISSUE_WIDTH-1:0]               grant_valid_q, grant_valid_d;
    logic                                 proto_err_q, proto_err_d;

    logic [DISPATCH_WIDTH-1:0][SIZE_LOG-1:0] pick_idx;
    logic [DISPATCH_WIDTH-1:0]               pick_valid;
    logic   entries_avail;
    logic   err;
    iqVec_t alloc_mask;
    iqVec_t grant_any;
    iqVec_t lane_vec;
    iqVec_t release_vec;
    iqVec_t kept_free;

    // Offers come from the registered free vector only, so a slot released
    // this cycle cannot be handed to dispatch until the next one.
    iq_lowest_k_select u_select (
        .free_vec   (free_vec_q),
        .pick_idx   (pick_idx),
        .pick_valid (pick_valid)
    );

    always_comb begin
        entries_avail = free_cnt_q >= iqCnt_t'(DISPATCH_WIDTH);
        err           = 1'b0;
        alloc_mask    = '0;
        grant_any     = '0;
        lane_vec      = '0;
        grant_idx_d   = '0;
        grant_valid_d = '0;

        for (int k = 0; k < DISPATCH_WIDTH; k++) begin
            if (dispatchValid_i[k] && entries_avail && pick_valid[k]) begin
                alloc_mask[pick_idx[k]] = 1'b1;
            end
        end
        if ((|dispatchValid_i) && !entries_avail) err = 1'b1;

        // Two lanes hitting one slot, or a lane with several bits, is a select-side bug.
        for (int k = 0; k < ISSUE_WIDTH; k++) begin
            lane_vec         = grantVec_i[k*IQ_SIZE +: IQ_SIZE];
            grant_valid_d[k] = |lane_vec;
            grant_idx_d[k]   = onehot_to_idx(lane_vec);
            if ((lane_vec & (lane_vec - iqVec_t'(1))) != '0) err = 1'b1;
            if ((lane_vec & grant_any) != '0) err = 1'b1;
            grant_any = grant_any | lane_vec;
        end

        release_vec = grant_any | flushVec_i;
        if ((release_vec & free_vec_q) != '0) err = 1'b1;

        kept_free   = free_vec_q & ~alloc_mask;
        free_vec_d  = kept_free | release_vec;
        free_cnt_d  = free_cnt_q - popcount(alloc_mask) + popcount(release_vec & ~kept_free);
        proto_err_d = proto_err_q | err;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            free_vec_q    <= '1;
            free_cnt_q    <= iqCnt_t'(IQ_SIZE);
            grant_idx_q   <= '0;
            grant_valid_q <= '0;
            proto_err_q   <= 1'b0;
        end else begin
            free_vec_q    <= free_vec_d;
            free_cnt_q    <= free_cnt_d;
            grant_idx_q   <= grant_idx_d;
            grant_valid_q <= grant_valid_d;
            proto_err_q   <= proto_err_d;
        end
    end

    assign grantIdx_o     = grant_idx_q;
    assign grantValid_o   = grant_valid_q;
    assign freeEntry_o    = pick_idx;
    assign entriesAvail_o = entries_avail;
    assign freeCnt_o      = free_cnt_q;
    assign protoErr_o     = proto_err_q;

endmodule

// File: tb/tb_iq_free_list.sv
// Directed and scoreboard-checked stimulus for the issue-queue free list.
module tb_iq_free_list;

    logic         clk = 1'b0;
    logic         reset;
    logic [127:0] grantVec_i;
    logic [19:0]  grantIdx_o;
    logic [3:0]   grantValid_o;
    logic [3:0]   dispatchValid_i;
    logic [19:0]  freeEntry_o;
    logic         entriesAvail_o;
    logic [31:0]  flushVec_i;
    logic [5:0]   freeCnt_o;
    logic         protoErr_o;

    int checks = 0;
    int errors = 0;

    iq_free_list dut (
        .clk             (clk),
        .reset           (reset),
        .grantVec_i      (grantVec_i),
        .grantIdx_o      (grantIdx_o),
        .grantValid_o    (grantValid_o),
        .dispatchValid_i (dispatchValid_i),
        .freeEntry_o     (freeEntry_o),
        .entriesAvail_o  (entriesAvail_o),
        .flushVec_i      (flushVec_i),
        .freeCnt_o       (freeCnt_o),
        .protoErr_o      (protoErr_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        grantVec_i      = '0;
        dispatchValid_i = '0;
        flushVec_i      = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic fill_queue();
        dispatchValid_i = 4'hF;
        repeat (8) tick();
        dispatchValid_i = '0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (freeCnt_o !== 6'd32) begin errors++; $display("[TB] FAIL reset_cnt got %0d want 32", freeCnt_o); end
        checks++; if (freeEntry_o !== {5'd3, 5'd2, 5'd1, 5'd0}) begin errors++; $display("[TB] FAIL reset_entries got %h want %h", freeEntry_o, {5'd3, 5'd2, 5'd1, 5'd0}); end
        checks++; if (entriesAvail_o !== 1'b1) begin errors++; $display("[TB] FAIL reset_avail got %b want 1", entriesAvail_o); end
        checks++; if (grantValid_o !== 4'b0000) begin errors++; $display("[TB] FAIL reset_gvalid got %b want 0000", grantValid_o); end
        checks++; if (grantIdx_o !== 20'd0) begin errors++; $display("[TB] FAIL reset_gidx got %h want 0", grantIdx_o); end
        checks++; if (protoErr_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_err got %b want 0", protoErr_o); end
    endtask

    task automatic test_fill();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            dispatchValid_i = 4'hF;
            tick();
            checks++; if (freeCnt_o !== 6'(32 - 4 * (i + 1))) begin errors++; $display("[TB] FAIL fill_cnt%0d got %0d want %0d", i, freeCnt_o, 32 - 4 * (i + 1)); end
            if (i < 7) begin
                checks++; if (freeEntry_o[4:0] !== 5'(4 * (i + 1))) begin errors++; $display("[TB] FAIL fill_lane0_%0d got %0d want %0d", i, freeEntry_o[4:0], 4 * (i + 1)); end
            end
        end
        dispatchValid_i = '0;
        checks++; if (entriesAvail_o !== 1'b0) begin errors++; $display("[TB] FAIL full_avail got %b want 0", entriesAvail_o); end
        checks++; if (protoErr_o !== 1'b0) begin errors++; $display("[TB] FAIL full_err got %b want 0", protoErr_o); end
        dispatchValid_i = 4'b0001;
        tick();
        dispatchValid_i = '0;
        checks++; if (freeCnt_o !== 6'd0) begin errors++; $display("[TB] FAIL overdisp_cnt got %0d want 0", freeCnt_o); end
        checks++; if (protoErr_o !== 1'b1) begin errors++; $display("[TB] FAIL overdisp_err got %b want 1", protoErr_o); end
        tick();
        checks++; if (protoErr_o !== 1'b1) begin errors++; $display("[TB] FAIL err_sticky got %b want 1", protoErr_o); end
    endtask

    task automatic test_grant_release();
        do_reset();
        fill_queue();
        grantVec_i[5]          = 1'b1;
        grantVec_i[2 * 32 + 17] = 1'b1;
        tick();
        clear_inputs();
        checks++; if (grantIdx_o[4:0] !== 5'd5) begin errors++; $display("[TB] FAIL grant_idx0 got %0d want 5", grantIdx_o[4:0]); end
        checks++; if (grantIdx_o[14:10] !== 5'd17) begin errors++; $display("[TB] FAIL grant_idx2 got %0d want 17", grantIdx_o[14:10]); end
        checks++; if (grantValid_o !== 4'b0101) begin errors++; $display("[TB] FAIL grant_valid got %b want 0101", grantValid_o); end
        checks++; if (freeCnt_o !== 6'd2) begin errors++; $display("[TB] FAIL grant_cnt got %0d want 2", freeCnt_o); end
        checks++; if (entriesAvail_o !== 1'b0) begin errors++; $display("[TB] FAIL grant_avail got %b want 0", entriesAvail_o); end
        checks++; if (freeEntry_o !== {5'd0, 5'd0, 5'd17, 5'd5}) begin errors++; $display("[TB] FAIL grant_entries got %h want %h", freeEntry_o, {5'd0, 5'd0, 5'd17, 5'd5}); end
        checks++; if (protoErr_o !== 1'b0) begin errors++; $display("[TB] FAIL grant_err got %b want 0", protoErr_o); end
        tick();
        checks++; if (grantValid_o !== 4'b0000) begin errors++; $display("[TB] FAIL grant_idle got %b want 0000", grantValid_o); end
    endtask

    task automatic test_flush_grant();
        do_reset();
        fill_queue();
        flushVec_i            = 32'hFFFF_0000;
        grantVec_i[32 + 20]   = 1'b1;
        tick();
        clear_inputs();
        checks++; if (freeCnt_o !== 6'd16) begin errors++; $display("[TB] FAIL flush_cnt got %0d want 16", freeCnt_o); end
        checks++; if (protoErr_o !== 1'b0) begin errors++; $display("[TB] FAIL flush_err got %b want 0", protoErr_o); end
        checks++; if (freeEntry_o !== {5'd19, 5'd18, 5'd17, 5'd16}) begin errors++; $display("[TB] FAIL flush_entries got %h want %h", freeEntry_o, {5'd19, 5'd18, 5'd17, 5'd16}); end
        checks++; if (grantIdx_o[9:5] !== 5'd20) begin errors++; $display("[TB] FAIL flush_gidx1 got %0d want 20", grantIdx_o[9:5]); end
        // Slots 0 and 1 are still busy, so only the non-one-hot lane can raise the error.
        grantVec_i[31:0] = 32'h0000_0003;
        tick();
        clear_inputs();
        checks++; if (grantIdx_o[4:0] !== 5'd0) begin errors++; $display("[TB] FAIL multihot_idx got %0d want 0", grantIdx_o[4:0]); end
        checks++; if (grantValid_o !== 4'b0001) begin errors++; $display("[TB] FAIL multihot_valid got %b want 0001", grantValid_o); end
        checks++; if (protoErr_o !== 1'b1) begin errors++; $display("[TB] FAIL multihot_err got %b want 1", protoErr_o); end
        checks++; if (freeCnt_o !== 6'd18) begin errors++; $display("[TB] FAIL multihot_cnt got %0d want 18", freeCnt_o); end
        checks++; if (freeEntry_o !== {5'd17, 5'd16, 5'd1, 5'd0}) begin errors++; $display("[TB] FAIL multihot_entries got %h want %h", freeEntry_o, {5'd17, 5'd16, 5'd1, 5'd0}); end
    endtask

    task automatic test_dup_grant();
        do_reset();
        fill_queue();
        grantVec_i[9]      = 1'b1;
        grantVec_i[96 + 9] = 1'b1;
        tick();
        clear_inputs();
        checks++; if (freeCnt_o !== 6'd1) begin errors++; $display("[TB] FAIL dup_cnt got %0d want 1", freeCnt_o); end
        checks++; if (protoErr_o !== 1'b1) begin errors++; $display("[TB] FAIL dup_err got %b want 1", protoErr_o); end
        checks++; if (freeEntry_o !== {5'd0, 5'd0, 5'd0, 5'd9}) begin errors++; $display("[TB] FAIL dup_entries got %h want %h", freeEntry_o, {5'd0, 5'd0, 5'd0, 5'd9}); end
        checks++; if (grantIdx_o[19:15] !== 5'd9) begin errors++; $display("[TB] FAIL dup_idx3 got %0d want 9", grantIdx_o[19:15]); end
        checks++; if (grantValid_o !== 4'b1001) begin errors++; $display("[TB] FAIL dup_valid got %b want 1001", grantValid_o); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        dispatchValid_i = 4'b0101;
        tick();
        checks++; if (freeCnt_o !== 6'd30) begin errors++; $display("[TB] FAIL partial_cnt got %0d want 30", freeCnt_o); end
        checks++; if (freeEntry_o !== {5'd5, 5'd4, 5'd3, 5'd1}) begin errors++; $display("[TB] FAIL partial_entries got %h want %h", freeEntry_o, {5'd5, 5'd4, 5'd3, 5'd1}); end
        dispatchValid_i = 4'hF;
        grantVec_i[2]   = 1'b1;
        tick();
        clear_inputs();
        checks++; if (freeCnt_o !== 6'd27) begin errors++; $display("[TB] FAIL b2b_cnt got %0d want 27", freeCnt_o); end
        checks++; if (freeEntry_o !== {5'd8, 5'd7, 5'd6, 5'd2}) begin errors++; $display("[TB] FAIL b2b_entries got %h want %h", freeEntry_o, {5'd8, 5'd7, 5'd6, 5'd2}); end
        checks++; if (protoErr_o !== 1'b0) begin errors++; $display("[TB] FAIL b2b_err got %b want 0", protoErr_o); end
    endtask

    task automatic test_free_hit_and_reset();
        do_reset();
        flushVec_i[0] = 1'b1;
        tick();
        clear_inputs();
        checks++; if (protoErr_o !== 1'b1) begin errors++; $display("[TB] FAIL freehit_err got %b want 1", protoErr_o); end
        checks++; if (freeCnt_o !== 6'd32) begin errors++; $display("[TB] FAIL freehit_cnt got %0d want 32", freeCnt_o); end
        dispatchValid_i = 4'hF;
        grantVec_i[3]   = 1'b1;
        reset           = 1'b1;
        tick();
        reset = 1'b0;
        clear_inputs();
        checks++; if (freeCnt_o !== 6'd32) begin errors++; $display("[TB] FAIL midreset_cnt got %0d want 32", freeCnt_o); end
        checks++; if (protoErr_o !== 1'b0) begin errors++; $display("[TB] FAIL midreset_err got %b want 0", protoErr_o); end
        checks++; if (grantValid_o !== 4'b0000) begin errors++; $display("[TB] FAIL midreset_gvalid got %b want 0000", grantValid_o); end
        checks++; if (freeEntry_o !== {5'd3, 5'd2, 5'd1, 5'd0}) begin errors++; $display("[TB] FAIL midreset_entries got %h want %h", freeEntry_o, {5'd3, 5'd2, 5'd1, 5'd0}); end
    endtask

    task automatic test_random();
        logic [31:0] mf;
        logic [31:0] granted;
        logic [31:0] alloc;
        logic [31:0] flush;
        logic [19:0] exp_entries;
        logic [19:0] exp_idx;
        logic [3:0]  exp_valid;
        logic [3:0]  disp;
        int          found;
        int          s;
        do_reset();
        mf = '1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            exp_entries = '0;
            found       = 0;
            for (int i = 0; i < 32; i++) begin
                if (mf[i] && found < 4) begin
                    exp_entries[found*5 +: 5] = 5'(i);
                    found++;
                end
            end
            checks++; if (freeCnt_o !== 6'($countones(mf))) begin errors++; $display("[TB] FAIL rnd_cnt c%0d got %0d want %0d", cyc, freeCnt_o, $countones(mf)); end
            checks++; if (freeEntry_o !== exp_entries) begin errors++; $display("[TB] FAIL rnd_entries c%0d got %h want %h", cyc, freeEntry_o, exp_entries); end
            checks++; if (entriesAvail_o !== ($countones(mf) >= 4)) begin errors++; $display("[TB] FAIL rnd_avail c%0d got %b", cyc, entriesAvail_o); end

            disp    = ($countones(mf) >= 4) ? 4'($urandom_range(0, 15)) : 4'b0000;
            granted = '0;
            exp_idx = '0;
            exp_valid = '0;
            grantVec_i = '0;
            for (int l = 0; l < 4; l++) begin
                if ($urandom_range(0, 1) == 1) begin
                    s = int'($urandom_range(0, 31));
                    if (!mf[s] && !granted[s]) begin
                        granted[s]            = 1'b1;
                        grantVec_i[l*32 + s]  = 1'b1;
                        exp_valid[l]          = 1'b1;
                        exp_idx[l*5 +: 5]     = 5'(s);
                    end
                end
            end
            flush = ($urandom_range(0, 7) == 0) ? ($urandom & ~mf) : 32'd0;
            alloc = '0;
            for (int k = 0; k < 4; k++) begin
                if (disp[k]) alloc[exp_entries[k*5 +: 5]] = 1'b1;
            end
            dispatchValid_i = disp;
            flushVec_i      = flush;
            tick();
            clear_inputs();
            mf = (mf & ~alloc) | granted | flush;
            checks++; if (grantValid_o !== exp_valid) begin errors++; $display("[TB] FAIL rnd_gvalid c%0d got %b want %b", cyc, grantValid_o, exp_valid); end
            checks++; if (grantIdx_o !== exp_idx) begin errors++; $display("[TB] FAIL rnd_gidx c%0d got %h want %h", cyc, grantIdx_o, exp_idx); end
            checks++; if (protoErr_o !== 1'b0) begin errors++; $display("[TB] FAIL rnd_err c%0d got %b want 0", cyc, protoErr_o); end
        end
    endtask

    initial begin
        reset = 1'b1;
        clear_inputs();
        test_reset();
        test_fill();
        test_grant_release();
        test_flush_grant();
        test_dup_grant();
        test_back_to_back();
        test_free_hit_and_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
